// File: rtl/fixed_point_square_pkg.sv
// rtl/fixed_point_square_pkg.sv - shared fixed-point widths and FSM state type for the squarer
// Square-root formats are shared: square input = sqrt output, square output = sqrt input.
package fixed_point_square_pkg;

   localparam int SQRT_OUT_INT_B = 8;
   localparam int SQRT_OUT_FP_B  = 16;
   localparam int SQRT_IN_INT_B  = 8;
   localparam int SQRT_IN_FP_B   = 4;
   localparam int unsigned ONE   = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_NORM  = 2'd2,
      ST_DONE  = 2'd3
   } sq_state_e;

endpackage

// File: rtl/fixed_point_square_accumulate.sv
// rtl/fixed_point_square_accumulate.sv - shift-add accumulator (module square_accumulate), one multiplier bit per step
// The multiplicand shifts left while the multiplier shifts right, so bit cnt is always at mplier_q[0].
module square_accumulate #(
   parameter int W = 24
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           step,
   input  logic [W-1:0]   x,
   output logic [2*W-1:0] acc
);

   logic [2*W-1:0] mcand_q, mcand_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic [2*W-1:0] acc_q, acc_d;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (load) begin
         mcand_d  = {{W{1'b0}}, x};
         mplier_d = x;
         acc_d    = '0;
      end else if (step) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/fixed_point_square.sv
// rtl/fixed_point_square.sv - sequential unsigned fixed-point squarer with saturation
// Define SQUARE_ROUND_EN for round-half-up normalisation; default build truncates.
module fixed_point_square
   import fixed_point_square_pkg::*;
#(
   parameter int IN_INT_B  = SQRT_OUT_INT_B,
   parameter int IN_FP_B   = SQRT_OUT_FP_B,
   parameter int OUT_INT_B = SQRT_IN_INT_B,
   parameter int OUT_FP_B  = SQRT_IN_FP_B
) (
   input  logic                          clk,
   input  logic                          rst_,
   input  logic                          start,
   input  logic [IN_INT_B+IN_FP_B-1:0]   X,
   output logic                          busy,
   output logic                          done,
   output logic [OUT_INT_B+OUT_FP_B-1:0] Y,
   output logic                          ovf
);

   localparam int W  = IN_INT_B + IN_FP_B;
   localparam int PW = 2 * W;
   localparam int YW = OUT_INT_B + OUT_FP_B;
   localparam int SH = 2 * IN_FP_B - OUT_FP_B;
   localparam int CW = $clog2(W) + 1;

   sq_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [YW-1:0]   y_q, y_d;
   logic            ovf_q, ovf_d;
   logic            load, step;
   logic [PW-1:0]   acc;
   logic [PW:0]     prod_r;
   logic [YW-1:0]   y_norm;
   logic            sat;
   logic            unused_low;

   square_accumulate #(.W(W)) u_acc (
      .clk   (clk),
      .rst_n (rst_),
      .load  (load),
      .step  (step),
      .x     (X),
      .acc   (acc)
   );

   // Extra top bit catches a carry out of the rounding add so it saturates.
`ifdef SQUARE_ROUND_EN
   assign prod_r = {1'b0, acc} + ((PW + 1)'(ONE) << (SH - 1));
`else
   assign prod_r = {1'b0, acc};
`endif

   assign y_norm     = prod_r[SH +: YW];
   assign sat        = |prod_r[PW:SH+YW];
   assign unused_low = &{1'b0, prod_r[SH-1:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      y_d     = y_q;
      ovf_d   = ovf_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load    = 1'b1;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            step  = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               state_d = ST_NORM;
            end
         end
         ST_NORM: begin
            y_d     = sat ? '1 : y_norm;
            ovf_d   = sat;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         y_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         y_q     <= y_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Y    = y_q;
   assign ovf  = ovf_q;

endmodule
